jk_bank_ctrl: RTL
=================

# jk_bank_ctrl

Round-robin controller that shares one bank of WIDTH JK flip-flop cells between N_REQ requesters. Each requester issues a 2-bit JK operation with a per-bit mask; the controller arbitrates and drives the J/K inputs of the selected bits for exactly one clock. It acknowledges completion with a one-cycle grant pulse. It is the sequencing layer above the JK flip-flop cell, and the bank is instantiated inside the block.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK cells in the bank
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  level request per requester; held until its gnt bit pulses
- op  in  2*N_REQ  per-requester operation {j,k}: 00 hold, 01 clear, 10 set, 11 toggle; requester i uses op[2i+1:2i]
- mask  in  N_REQ*WIDTH  per-requester bit select; requester i uses mask[WIDTH*i +: WIDTH]
- gnt  out  N_REQ  one-hot, one-cycle completion pulse
- done  out  1  high in the same cycle as any gnt bit
- busy  out  1  high whenever state is not IDLE
- q  out  WIDTH  bank contents
- q_bar  out  WIDTH  ~q

## Operation
- FSM states: IDLE, APPLY, ACK.
- IDLE:
  - If any eligible req is high, pick the first one at or after ptr, wrapping modulo N_REQ.
  - Latch its index, op and mask into sel_idx, sel_op and sel_mask, then go to APPLY.
  - Otherwise stay in IDLE.
- APPLY:
  - For every bit b, j[b] = sel_op[1] & sel_mask[b] and k[b] = sel_op[0] & sel_mask[b].
  - The bank updates at the end of this cycle. Go to ACK.
- ACK:
  - gnt[sel_idx] = 1 and done = 1.
  - ptr <= (sel_idx+1) mod N_REQ. Go to IDLE.
- In the IDLE cycle that immediately follows ACK, req[sel_idx] is ineligible (one-cycle holdoff). This covers the requester's one-cycle reaction time to gnt.
- The requester deasserts req in the cycle after gnt. If it keeps req high, it is served again in its normal round-robin turn.
- Outside APPLY, all J/K inputs are 0, so the bank holds.
- Cell semantics: 00 hold, 01 q=0, 10 q=1, 11 q=~q. Bits with mask=0 are untouched.
- op and mask are sampled only in IDLE. Changes after that point have no effect on the in-flight operation.
- A mask of all zeros, or op=00, still completes a full handshake with q unchanged.
- Reset values:
  - state IDLE, ptr 0, q 0, q_bar all ones.
  - gnt 0, done 0, busy 0; sel_* registers 0.

## Timing
- Request-to-grant latency:
  - req is high in cycle 0 (IDLE).
  - APPLY is cycle 1.
  - gnt, done and the new q are visible in cycle 2.
- Throughput: one operation per 3 cycles. Back-to-back different requesters give gnt pulses 3 cycles apart.
- Simultaneous requests: served strictly in round-robin order starting from ptr. No requester waits more than N_REQ operations.
- Wrap-around: after the grant to requester N_REQ-1, ptr returns to 0.
- rst asserted in any state, including mid-APPLY or ACK:
  - Next cycle is IDLE with q=0.
  - No gnt is issued for the in-flight operation, and ptr returns to 0.
  - rst has priority over the J/K update on the same edge.
- A req withdrawn before it is sampled in IDLE is not served and gets no gnt.
- A req withdrawn after it is sampled completes normally.

## Structure
- Package jk_bank_pkg holds:
  - op encodings OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TGL=2'b11
  - FSM state type {IDLE, APPLY, ACK}
- Sub-module jk_cell:
  - One JK flip-flop with ports j, k, clk, rst (synchronous, active-high), q and q_bar.
  - Instantiated WIDTH times by a generate loop.
- Round-robin selection is a combinational function of req, the holdoff and ptr, written inside jk_bank_ctrl.

## Test plan
- After reset, q=8'h00, q_bar=8'hFF, gnt=0, busy=0. Then req[0] with op=10, mask=8'h0F: gnt[0] and done pulse in cycle 2 with q=8'h0F, and busy is high in cycles 1-2.
- req[2] toggles q (op=11) with mask=8'hFF starting from q=8'h0F, giving q=8'hF0. A second op=11 with mask=8'h81 gives q=8'h71. Then op=01 with mask=8'hF0 gives q=8'h01.
- All four req high in the same cycle after reset with a mask of distinct bits each: grants arrive in order 0,1,2,3, each pulse 3 cycles apart. Then ptr wraps, and the next simultaneous burst again starts at 0.
- req[1] held high after its gnt, with req[3] also pending: next grant goes to 3, then to 1. req[1] alone held high: it is re-granted with 4 cycles between gnt pulses, which reflects the holdoff cycle.
- rst pulsed during APPLY of an op=10 with mask=8'hFF: no gnt, q=8'h00, state IDLE and ptr=0 on the following cycle.
- op=00 with mask=8'hFF, and separately op=11 with mask=8'h00: a full handshake completes with gnt pulsed and q unchanged.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg
// Shared definitions for the JK bank controller: the 2-bit {j,k} operation
// encodings and the controller FSM state type.
package jk_bank_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/jk_cell.sv
// jk_cell
// One JK flip-flop.
// Ports:
//   clk   - clock, updates on posedge
//   rst   - synchronous active-high reset, wins over j/k
//   j, k  - 00 hold, 01 clear, 10 set, 11 toggle
//   q     - stored bit
//   q_bar - ~q
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl
// Round-robin sequencer sharing one bank of WIDTH JK cells between N_REQ
// requesters. One operation takes three cycles: IDLE (select), APPLY (drive
// J/K for the masked bits), ACK (grant pulse).
//
// Handshake: req[i] is a level valid held by requester i until gnt[i]
// pulses; gnt[i] is the one-cycle completion (ready) response. op/mask are
// sampled only in the IDLE cycle that selects the requester. In the IDLE
// cycle directly after ACK the just-served requester is ineligible, so a
// requester may take one cycle to drop req after its grant.
//
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   req        - per-requester level request
//   op         - per-requester {j,k}; requester i uses op[2i+1:2i]
//   mask       - per-requester bit select; requester i uses mask[WIDTH*i +: WIDTH]
//   gnt        - one-hot completion pulse
//   done       - high with any gnt bit
//   busy       - high whenever the FSM is not IDLE
//   q, q_bar   - bank contents and complement
//   dbg_state  - current FSM state
//   dbg_ptr    - round-robin pointer
module jk_bank_ctrl
    import jk_bank_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         op,
    input  logic [N_REQ*WIDTH-1:0]     mask,
    output logic [N_REQ-1:0]           gnt,
    output logic                       done,
    output logic                       busy,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output state_t                     dbg_state,
    output logic [$clog2(N_REQ)-1:0]   dbg_ptr
);

    localparam int IDXW = $clog2(N_REQ);
    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(N_REQ);

    state_t            state, state_nxt;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   sel_idx;
    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  sel_mask;
    logic              holdoff;

    logic [N_REQ-1:0]  elig;
    logic              found;
    logic [IDXW-1:0]   pick;
    logic [1:0]        pick_op;
    logic [WIDTH-1:0]  pick_mask;
    logic [WIDTH-1:0]  j, k;

    // Round-robin pick: first eligible requester at or after ptr. The
    // candidate index is kept one bit wider so ptr+i can wrap modulo N_REQ
    // even when N_REQ is not a power of two.
    always_comb begin
        logic [IDXW:0] cand;
        cand      = '0;
        elig      = req;
        found     = 1'b0;
        pick      = '0;
        pick_op   = '0;
        pick_mask = '0;
        if (holdoff) elig[sel_idx] = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IDXW+1)'(i);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!found && elig[cand[IDXW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDXW-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IDXW'(i)) begin
                pick_op   = op[2*i +: 2];
                pick_mask = mask[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = 1'b0;
        busy      = (state != IDLE);
        j         = '0;
        k         = '0;
        case (state)
            IDLE: begin
                if (found) state_nxt = APPLY;
            end
            APPLY: begin
                j         = {WIDTH{sel_op[1]}} & sel_mask;
                k         = {WIDTH{sel_op[0]}} & sel_mask;
                state_nxt = ACK;
            end
            ACK: begin
                gnt[sel_idx] = 1'b1;
                done         = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            sel_idx  <= '0;
            sel_op   <= '0;
            sel_mask <= '0;
            holdoff  <= 1'b0;
        end else begin
            // Holdoff is live only in the IDLE cycle right after ACK.
            holdoff <= (state == ACK);
            if (state == IDLE && found) begin
                sel_idx  <= pick;
                sel_op   <= pick_op;
                sel_mask <= pick_mask;
            end
            if (state == ACK) begin
                ptr <= (sel_idx == IDXW'(N_REQ-1)) ? '0 : sel_idx + 1'b1;
            end
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        jk_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .j     (j[b]),
            .k     (k[b]),
            .q     (q[b]),
            .q_bar (q_bar[b])
        );
    end

    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule
